// File: rtl/t08_mem_pkg.sv
// Shared types and constants for the t08 data-memory stage.
//   mem_state_t : bus transaction FSM state
//   F3_*        : funct3 access size/sign encodings
//   f3_legal()  : whether a funct3 code is a supported access for a load or a store
package t08_mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants only make sense for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !is_store;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/t08_mem_lane_align.sv
// Combinational byte-lane logic for one access.
//   funct3_i     : access size/sign
//   addr_i       : byte offset within the word
//   store_data_i : rs2 value for stores
//   rdata_i      : bus read word
//   sel_o        : byte enables
//   wdata_o      : store data replicated onto every lane
//   load_ext_o   : extracted and sign/zero-extended load value
//   misaligned_o : halfword/word access not on its natural boundary
module t08_mem_lane_align
  import t08_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_ext_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_v = rdata_i[{addr_i[1], 4'b0000} +: 16];

  always_comb begin
    sel_o        = 4'b0000;
    wdata_o      = store_data_i;
    load_ext_o   = 32'h0;
    misaligned_o = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        sel_o      = 4'b0001 << addr_i;
        wdata_o    = {4{store_data_i[7:0]}};
        load_ext_o = (funct3_i == F3_B) ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      end
      F3_H, F3_HU: begin
        sel_o        = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{store_data_i[15:0]}};
        load_ext_o   = (funct3_i == F3_H) ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
        misaligned_o = addr_i[0];
      end
      F3_W: begin
        sel_o        = 4'b1111;
        load_ext_o   = rdata_i;
        misaligned_o = |addr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/t08_memory_handler.sv
// Data-memory stage: turns one load/store from the control unit into a single
// req/ack bus transaction and freezes the core until it completes.
//   clk, nRst          : clock, async active-low reset
//   read, write        : load / store present
//   funct3             : access size/sign
//   addr, store_data   : byte address, rs2 value
//   mem_ack, mem_rdata : bus completion pulse and read word
//   mem_req .. mem_sel : bus request, direction, word address, lane data, byte enables
//   freeze             : stall PC/writeback
//   load_data          : extended load result (held until next load)
//   load_valid, err    : one-cycle pulses in DONE
//
// state | meaning
// IDLE  | waiting for a memory instruction; legal ones latch and go to REQ
// REQ   | mem_req high, waiting for mem_ack or timeout
// DONE  | one cycle: pulses load_valid/err, releases freeze
module t08_memory_handler
  import t08_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  output logic        freeze,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        err
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LOAD = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  mem_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        lv_q, lv_d;
  logic [31:0] ld_q, ld_d;

  logic [2:0]  al_f3;
  logic [1:0]  al_b;
  logic [3:0]  al_sel;
  logic [31:0] al_wdata;
  logic [31:0] al_ext;
  logic        al_mis;

  // The aligner sees the live instruction while deciding in IDLE and the
  // latched copy while a transaction is outstanding.
  assign al_f3 = (state_q == IDLE) ? funct3 : f3_q;
  assign al_b  = (state_q == IDLE) ? addr[1:0] : b_q;

  t08_mem_lane_align u_align (
    .funct3_i     (al_f3),
    .addr_i       (al_b),
    .store_data_i (store_data),
    .rdata_i      (mem_rdata),
    .sel_o        (al_sel),
    .wdata_o      (al_wdata),
    .load_ext_o   (al_ext),
    .misaligned_o (al_mis)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    f3_d    = f3_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    err_d   = 1'b0;
    lv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          if ((read ^ write) && f3_legal(funct3, write) && !al_mis) begin
            state_d = REQ;
            we_d    = write;
            addr_d  = {addr[31:2], 2'b00};
            wdata_d = al_wdata;
            sel_d   = al_sel;
            f3_d    = funct3;
            b_d     = addr[1:0];
            cnt_d   = TO_LOAD;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
            if (read) begin
              lv_d = 1'b1;
              ld_d = 32'h0;
            end
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
          if (!we_q) begin
            lv_d = 1'b1;
            ld_d = al_ext;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == '0)) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (!we_q) begin
            lv_d = 1'b1;
            ld_d = 32'h0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      sel_q   <= 4'b0000;
      f3_q    <= 3'b000;
      b_q     <= 2'b00;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      lv_q    <= 1'b0;
      ld_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      f3_q    <= f3_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      lv_q    <= lv_d;
      ld_q    <= ld_d;
    end
  end

  assign mem_req    = (state_q == REQ);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_sel    = sel_q;
  assign freeze     = (state_q == REQ) || ((state_q == IDLE) && (read || write));
  assign load_data  = ld_q;
  assign load_valid = lv_q;
  assign err        = err_q;

endmodule

// File: tb/tb_t08_memory_handler.sv
module tb_t08_memory_handler;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        read = 1'b0, write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0, store_data = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_req, mem_we, freeze, load_valid, err;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_sel;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] last_ld = 32'h0;

  t08_memory_handler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .nRst(nRst), .read(read), .write(write), .funct3(funct3),
    .addr(addr), .store_data(store_data), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .freeze(freeze), .load_data(load_data),
    .load_valid(load_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Drives one instruction, answers the bus after wt wait states, and checks
  // everything against a reference computed from the access rules.
  task automatic run_op(input string nm, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdv,
                        input int wt, input bit gap);
    int nb, b, fz, rq, exp_fz, exp_rq;
    bit legal, timed, done;
    logic [31:0] mask, exp_wd, ext, exp_ld;
    logic [3:0] exp_sel;
    nb = 1 << f3[1:0];
    b = int'(a[1:0]);
    legal = (rd != wr) && (f3[1:0] != 2'd3) && (!f3[2] || (nb != 4 && !wr)) && ((b % nb) == 0);
    mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    exp_sel = 4'(((1 << nb) - 1) << b);
    exp_wd = (nb == 1) ? {24'h0, sd[7:0]} * 32'h0101_0101 :
             (nb == 2) ? {16'h0, sd[15:0]} * 32'h0001_0001 : sd;
    ext = (rdv >> (8 * b)) & mask;
    if (!f3[2] && nb < 4 && ((ext >> (8 * nb - 1)) & 32'd1) != 0) ext = ext | ~mask;
    timed = legal && (wt >= TO);
    exp_rq = !legal ? 0 : (timed ? TO : wt + 1);
    exp_fz = 1 + exp_rq;
    exp_ld = rd ? ((legal && !timed) ? ext : 32'h0) : last_ld;

    @(negedge clk);
    read = rd; write = wr; funct3 = f3; addr = a; store_data = sd; mem_ack = 1'b0;
    fz = 0; rq = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (freeze) fz++;
      if (mem_req) begin
        rq++;
        total_cnt++;
        if ({mem_we, mem_addr, mem_sel, mem_wdata} !== {wr, a[31:2], 2'b00, exp_sel, exp_wd})
          $display("FAIL %s bus: got we=%b addr=%h sel=%b wd=%h want we=%b addr=%h sel=%b wd=%h",
                   nm, mem_we, mem_addr, mem_sel, mem_wdata, wr, {a[31:2], 2'b00}, exp_sel, exp_wd);
        else pass_cnt++;
        mem_ack = (rq == wt + 1);
        mem_rdata = mem_ack ? rdv : $urandom;
      end else begin
        mem_ack = 1'b0;
      end
      if (c > 0 && !freeze && !mem_req) begin
        done = 1;
        total_cnt++;
        if (fz !== exp_fz || rq !== exp_rq)
          $display("FAIL %s timing: got freeze=%0d req=%0d want freeze=%0d req=%0d", nm, fz, rq, exp_fz, exp_rq);
        else pass_cnt++;
        total_cnt++;
        if (err !== (!legal || timed))
          $display("FAIL %s err: got %b want %b", nm, err, !legal || timed);
        else pass_cnt++;
        if (!(rd && wr)) begin
          total_cnt++;
          if (load_valid !== rd || load_data !== exp_ld)
            $display("FAIL %s load: got lv=%b ld=%h want lv=%b ld=%h", nm, load_valid, load_data, rd, exp_ld);
          else pass_cnt++;
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL %s no DONE: got freeze=%b req=%b want DONE within 40 cycles", nm, freeze, mem_req);
    end
    if (rd) last_ld = exp_ld;
    if (gap) begin
      read = 1'b0; write = 1'b0;
      @(negedge clk); #1;
      total_cnt++;
      if ({err, load_valid, mem_req, freeze} !== 4'b0000)
        $display("FAIL %s after: got err=%b lv=%b req=%b fz=%b want all 0", nm, err, load_valid, mem_req, freeze);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    #13;
    total_cnt++;
    if ({mem_req, mem_we, mem_sel, load_valid, err, freeze} !== 8'h00 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || load_data !== 32'h0)
      $display("FAIL reset: got req=%b we=%b sel=%b lv=%b err=%b addr=%h wd=%h ld=%h want all 0",
               mem_req, mem_we, mem_sel, load_valid, err, mem_addr, mem_wdata, load_data);
    else pass_cnt++;
    @(negedge clk);
    nRst = 1'b1;
  endtask

  task automatic test_idle_nop();
    @(negedge clk);
    read = 1'b0; write = 1'b0; funct3 = 3'b001; addr = 32'h1235;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if ({mem_req, freeze, load_valid, err} !== 4'b0000)
        $display("FAIL nop: got req=%b fz=%b lv=%b err=%b want 0000", mem_req, freeze, load_valid, err);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_directed();
    run_op("sw",      1'b0, 1'b1, 3'b010, 32'h1004, 32'hDEADBEEF, 32'h0, 0, 1);
    run_op("lb",      1'b1, 1'b0, 3'b000, 32'h2003, 32'h0, 32'h80FFFFFF, 0, 1);
    run_op("lbu",     1'b1, 1'b0, 3'b100, 32'h2003, 32'h0, 32'h80FFFFFF, 0, 1);
    run_op("sh",      1'b0, 1'b1, 3'b001, 32'h3002, 32'h0000ABCD, 32'h0, 1, 1);
    run_op("lhu",     1'b1, 1'b0, 3'b101, 32'h3002, 32'h0, 32'hABCD0000, 0, 1);
    run_op("lh_neg",  1'b1, 1'b0, 3'b001, 32'h3000, 32'h0, 32'h1234_8001, 2, 1);
    run_op("lw_mis",  1'b1, 1'b0, 3'b010, 32'h4001, 32'h0, 32'h0, 0, 1);
    run_op("sbu_bad", 1'b0, 1'b1, 3'b100, 32'h4000, 32'h55, 32'h0, 0, 1);
  endtask

  task automatic test_timeout();
    run_op("lw_prime", 1'b1, 1'b0, 3'b010, 32'h6000, 32'h0, 32'hCAFEF00D, 3, 1);
    run_op("lw_to",    1'b1, 1'b0, 3'b010, 32'h6004, 32'h0, 32'h0, 100, 1);
    run_op("sw_to",    1'b0, 1'b1, 3'b010, 32'h6008, 32'h1111, 32'h0, 100, 1);
  endtask

  task automatic test_read_write_reject();
    run_op("rw_both", 1'b1, 1'b1, 3'b010, 32'h7000, 32'h0, 32'h0, 0, 1);
    run_op("lb_sync", 1'b1, 1'b0, 3'b000, 32'h7001, 32'h0, 32'h0000_7F00, 0, 1);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_lw0", 1'b1, 1'b0, 3'b010, 32'h8000, 32'h0, 32'h0102_0304, 2, 0);
    run_op("b2b_lw1", 1'b1, 1'b0, 3'b010, 32'h8004, 32'h0, 32'hA5A5_5A5A, 2, 1);
  endtask

  task automatic test_reset_mid_req();
    bit seen = 0;
    @(negedge clk);
    read = 1'b1; write = 1'b0; funct3 = 3'b010; addr = 32'h5000; mem_ack = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      #1;
      if (mem_req) seen = 1;
      else @(negedge clk);
    end
    total_cnt++;
    if (!seen) $display("FAIL rst_req: got req=0 want req=1 before reset");
    else pass_cnt++;
    nRst = 1'b0;
    read = 1'b0;
    #1;
    total_cnt++;
    if ({mem_req, mem_we, mem_sel, load_valid, err, freeze} !== 8'h00 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || load_data !== 32'h0)
      $display("FAIL rst_mid: got req=%b we=%b sel=%b lv=%b err=%b addr=%h ld=%h want all 0",
               mem_req, mem_we, mem_sel, load_valid, err, mem_addr, load_data);
    else pass_cnt++;
    last_ld = 32'h0;
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      mem_ack = 1'b0;
      total_cnt++;
      if ({mem_req, load_valid, err} !== 3'b000 || load_data !== 32'h0)
        $display("FAIL late_ack: got req=%b lv=%b err=%b ld=%h want 0,0,0,0", mem_req, load_valid, err, load_data);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 50; i++) begin
      logic rd;
      logic [31:0] a;
      rd = 1'($urandom_range(0, 1));
      a = $urandom;
      run_op($sformatf("rnd%0d", i), rd, !rd, 3'($urandom_range(0, 7)), a,
             $urandom, $urandom, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_idle_nop();
    test_directed();
    test_timeout();
    test_read_write_reject();
    test_back_to_back();
    test_reset_mid_req();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
